// File: rtl/rect_pkg.sv
// rect_pkg: corner encodings, raster defaults and colour field layout shared by the
// rectilinearizer blocks (corner locator, corner sprites, corner registers).
package rect_pkg;
    localparam logic [1:0] CORNER_TL = 2'd0;
    localparam logic [1:0] CORNER_TR = 2'd1;
    localparam logic [1:0] CORNER_BL = 2'd2;
    localparam logic [1:0] CORNER_BR = 2'd3;
    localparam int H_ACTIVE_DEF = 1024;
    localparam int V_ACTIVE_DEF = 768;
    localparam int CH_W  = 10;
    localparam int R_LSB = 20;
    localparam int G_LSB = 10;
    localparam int B_LSB = 0;
    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_SCAN,
        S_DONE
    } loc_state_e;
    function automatic logic within_tol(input logic [CH_W-1:0] a, input logic [CH_W-1:0] b,
                                        input logic [CH_W-1:0] tol);
        return ((a > b) ? a - b : b - a) <= tol;
    endfunction
endpackage

// File: rtl/colour_match.sv
// colour_match: flags a pixel whose R, G and B channels each lie within TOL of COLOUR.
module colour_match
    import rect_pkg::*;
#(
    parameter logic [29:0] COLOUR = 30'h3FFFFFFF,
    parameter logic [9:0]  TOL    = 10'd64
) (
    input  logic [29:0] pixel,
    output logic        hit
);
    always_comb
        hit = within_tol(pixel[R_LSB +: CH_W], COLOUR[R_LSB +: CH_W], TOL)
           && within_tol(pixel[G_LSB +: CH_W], COLOUR[G_LSB +: CH_W], TOL)
           && within_tol(pixel[B_LSB +: CH_W], COLOUR[B_LSB +: CH_W], TOL);
endmodule

// File: rtl/corner_locator.sv
// corner_locator: scans one full frame on request and reports the pixel of COLOUR
// closest (Manhattan distance) to the chosen screen corner, plus the match count.
module corner_locator
    import rect_pkg::*;
#(
    parameter int          H_ACTIVE   = H_ACTIVE_DEF,
    parameter int          V_ACTIVE   = V_ACTIVE_DEF,
    parameter logic [29:0] COLOUR     = 30'h3FFFFFFF,
    parameter logic [9:0]  TOL        = 10'd64,
    parameter logic [1:0]  CORNER     = CORNER_TL,
    parameter logic [19:0] MIN_PIXELS = 20'd16
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [10:0] hcount,
    input  logic [9:0]  vcount,
    input  logic [29:0] pixel,
    input  logic        req,
    output logic        busy,
    output logic        done,
    output logic        found,
    output logic [10:0] x,
    output logic [9:0]  y,
    output logic [19:0] match_count
);
    localparam logic [10:0] H_ACT  = 11'(H_ACTIVE);
    localparam logic [9:0]  V_ACT  = 10'(V_ACTIVE);
    localparam logic [10:0] H_END  = 11'(H_ACTIVE - 1);
    localparam logic [9:0]  V_END  = 10'(V_ACTIVE - 1);
    localparam logic [11:0] H_LAST = 12'(H_ACTIVE - 1);
    localparam logic [11:0] V_LAST = 12'(V_ACTIVE - 1);
    localparam logic        FLIP_H = (CORNER == CORNER_TR) || (CORNER == CORNER_BR);
    localparam logic        FLIP_V = (CORNER == CORNER_BL) || (CORNER == CORNER_BR);

    loc_state_e  state_q, state_d;
    logic        colour_hit, active, frame_start, last_px;
    logic [11:0] h_term, v_term, score;
    logic        s1_m_q, s1_m_d;
    logic [10:0] s1_h_q, s1_h_d;
    logic [9:0]  s1_v_q, s1_v_d;
    logic [11:0] best_score_q, best_score_d;
    logic [10:0] best_x_q, best_x_d;
    logic [9:0]  best_y_q, best_y_d;
    logic [19:0] count_q, count_d;
    logic        found_q, found_d;
    logic [10:0] x_q, x_d;
    logic [9:0]  y_q, y_d;
    logic [19:0] mc_q, mc_d;

    colour_match #(
        .COLOUR(COLOUR),
        .TOL   (TOL)
    ) u_match (
        .pixel(pixel),
        .hit  (colour_hit)
    );

    always_comb begin
        active      = (hcount < H_ACT) && (vcount < V_ACT);
        frame_start = (hcount == '0) && (vcount == '0);
        last_px     = (s1_h_q == H_END) && (s1_v_q == V_END);
        h_term      = FLIP_H ? H_LAST - {1'b0, s1_h_q} : {1'b0, s1_h_q};
        v_term      = FLIP_V ? V_LAST - {2'b0, s1_v_q} : {2'b0, s1_v_q};
        score       = h_term + v_term;
    end

    always_ff @(posedge clock or negedge reset_n)
        if (!reset_n)
            state_q <= S_IDLE;
        else
            state_q <= state_d;

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  state_d = req ? S_WAIT : S_IDLE;
            S_WAIT:  state_d = frame_start ? S_SCAN : S_WAIT;
            S_SCAN:  state_d = last_px ? S_DONE : S_SCAN;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q == S_WAIT) || (state_q == S_SCAN);
        done = state_q == S_DONE;
    end

    // Results are published on the last scan cycle so they are valid while done is high.
    always_comb begin
        s1_m_d       = active && colour_hit;
        s1_h_d       = hcount;
        s1_v_d       = vcount;
        best_score_d = best_score_q;
        best_x_d     = best_x_q;
        best_y_d     = best_y_q;
        count_d      = count_q;
        found_d      = found_q;
        x_d          = x_q;
        y_d          = y_q;
        mc_d         = mc_q;
        if (state_q == S_IDLE && req) begin
            best_score_d = '1;
            best_x_d     = '0;
            best_y_d     = '0;
            count_d      = '0;
        end
        if (state_q == S_SCAN && s1_m_q) begin
            count_d = &count_q ? count_q : count_q + 20'd1;
            if (score < best_score_q) begin
                best_score_d = score;
                best_x_d     = s1_h_q;
                best_y_d     = s1_v_q;
            end
        end
        if (state_q == S_SCAN && last_px) begin
            found_d = count_d >= MIN_PIXELS;
            x_d     = best_x_d;
            y_d     = best_y_d;
            mc_d    = count_d;
        end
    end

    always_ff @(posedge clock or negedge reset_n)
        if (!reset_n) begin
            s1_m_q       <= 1'b0;
            s1_h_q       <= '0;
            s1_v_q       <= '0;
            best_score_q <= '0;
            best_x_q     <= '0;
            best_y_q     <= '0;
            count_q      <= '0;
            found_q      <= 1'b0;
            x_q          <= '0;
            y_q          <= '0;
            mc_q         <= '0;
        end else begin
            s1_m_q       <= s1_m_d;
            s1_h_q       <= s1_h_d;
            s1_v_q       <= s1_v_d;
            best_score_q <= best_score_d;
            best_x_q     <= best_x_d;
            best_y_q     <= best_y_d;
            count_q      <= count_d;
            found_q      <= found_d;
            x_q          <= x_d;
            y_q          <= y_d;
            mc_q         <= mc_d;
        end

    assign found       = found_q;
    assign x           = x_q;
    assign y           = y_q;
    assign match_count = mc_q;
endmodule

// File: tb/tb_corner_locator.sv
// tb_corner_locator: four instances (one per corner) on a reduced raster, checked
// against a table of directed frames and a pixel-scan reference model for random frames.
module tb_corner_locator;
    localparam int HA    = 48;
    localparam int VA    = 24;
    localparam int HT    = 56;
    localparam int VT    = 28;
    localparam int FRAME = HT * VT;
    localparam int LAST  = (VA - 1) * HT + HA - 1;
    localparam int TOL   = 64;
    localparam logic [29:0] WHITE    = 30'h3FFFFFFF;
    localparam logic [29:0] NEAR_IN  = {10'h3FF, 10'h3BF, 10'h3C0};
    localparam logic [29:0] NEAR_OUT = {10'h3FF, 10'h3BE, 10'h3C0};

    typedef struct packed {
        logic [1:0]  scen;
        logic [1:0]  corner;
        logic        found;
        logic [19:0] mc;
        logic [10:0] x;
        logic [9:0]  y;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req = 1'b0;
    logic [10:0] hcount = '0;
    logic [9:0]  vcount = '0;
    logic [29:0] pixel = '0;
    logic [3:0]  busy_w, done_w, found_w;
    logic [10:0] x_w [4];
    logic [9:0]  y_w [4];
    logic [19:0] mc_w [4];

    logic [29:0] img [VT][HT];
    vec_t        vecs [16];
    int          cyc = 0, pos = FRAME - 1, n_chk = 0, n_fail = 0;
    int          done_cnt [4];
    int          done_at [4];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        corner_locator #(
            .H_ACTIVE(HA),
            .V_ACTIVE(VA),
            .CORNER  (2'(g))
        ) u_dut (
            .clock      (clk),
            .reset_n    (rst_n),
            .hcount     (hcount),
            .vcount     (vcount),
            .pixel      (pixel),
            .req        (req),
            .busy       (busy_w[g]),
            .done       (done_w[g]),
            .found      (found_w[g]),
            .x          (x_w[g]),
            .y          (y_w[g]),
            .match_count(mc_w[g])
        );
    end

    task automatic check(input string name, input int k, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s corner%0d: got %0d, expected %0d", name, k, act, exp);
        end
    endtask

    task automatic tick(input logic r);
        @(negedge clk);
        cyc++;
        for (int k = 0; k < 4; k++)
            if (done_w[k]) begin
                done_cnt[k]++;
                done_at[k] = cyc;
            end
        pos    = (pos + 1) % FRAME;
        hcount = 11'(pos % HT);
        vcount = 10'(pos / HT);
        pixel  = img[pos / HT][pos % HT];
        req    = r;
    endtask

    task automatic advance_to(input int p);
        while ((pos + 1) % FRAME != p) tick(1'b0);
    endtask

    task automatic build(input int s);
        int dens;
        logic [9:0] r, g, b;
        dens = $urandom_range(15, 60);
        for (int v = 0; v < VT; v++)
            for (int h = 0; h < HT; h++)
                img[v][h] = (h >= HA || v >= VA) ? WHITE : 30'h0;
        case (s)
            0: for (int j = 0; j < 4; j++) for (int i = 0; i < 4; i++) img[5 + j][10 + i] = WHITE;
            2: begin
                img[8][4] = WHITE;
                img[4][8] = WHITE;
                for (int i = 30; i <= 43; i++) img[20][i] = WHITE;
            end
            3: for (int i = 0; i < HA; i++) begin
                img[2][i] = NEAR_OUT;
                if (i >= 5 && i <= 20) img[3][i] = NEAR_IN;
            end
            4: for (int v = 0; v < VA; v++)
                for (int h = 0; h < HA; h++)
                    if ($urandom_range(0, dens - 1) == 0) begin
                        r = 10'(1023 - $urandom_range(0, 70));
                        g = 10'(1023 - $urandom_range(0, 70));
                        b = 10'(1023 - $urandom_range(0, 70));
                        img[v][h] = {r, g, b};
                    end
            default: ;
        endcase
    endtask

    function automatic bit near(input logic [9:0] a);
        return (1023 - int'(a)) <= TOL;
    endfunction

    // Reference: walk the visible area in raster order keeping the first strictly-closest match.
    task automatic model(input int k, output int ex, output int ey, output int ec);
        int best, d;
        logic [29:0] p;
        best = 1 << 20;
        ex = 0; ey = 0; ec = 0;
        for (int v = 0; v < VA; v++)
            for (int h = 0; h < HA; h++) begin
                p = img[v][h];
                if (near(p[29:20]) && near(p[19:10]) && near(p[9:0])) begin
                    d = ((k == 1 || k == 3) ? HA - 1 - h : h) + ((k >= 2) ? VA - 1 - v : v);
                    ec++;
                    if (d < best) begin
                        best = d;
                        ex = h;
                        ey = v;
                    end
                end
            end
    endtask

    task automatic measure(input string name, input int scen, input int extra_req);
        int d0 [4];
        int ex [4], ey [4], ec [4], ef [4];
        int exp_done, k;
        for (int i = 0; i < 4; i++) begin
            d0[i] = done_cnt[i];
            if (scen < 0) begin
                model(i, ex[i], ey[i], ec[i]);
                ef[i] = (ec[i] >= 16) ? 1 : 0;
            end
        end
        if (scen >= 0)
            for (int i = 0; i < 16; i++)
                if (int'(vecs[i].scen) == scen) begin
                    k = int'(vecs[i].corner);
                    ex[k] = int'(vecs[i].x);
                    ey[k] = int'(vecs[i].y);
                    ec[k] = int'(vecs[i].mc);
                    ef[k] = int'(vecs[i].found);
                end
        tick(1'b1);
        exp_done = cyc + FRAME - pos + LAST + 2;
        tick(1'b0);
        for (int i = 0; i < 4; i++) check({name, ".busy_after_req"}, i, int'(busy_w[i]), 1);
        for (int i = 0; i < 3 * FRAME && done_cnt[0] == d0[0]; i++) tick(i == extra_req);
        for (int i = 0; i < 4; i++) tick(1'b0);
        for (int i = 0; i < 4; i++) begin
            check({name, ".done_pulses"}, i, done_cnt[i] - d0[i], 1);
            check({name, ".done_cycle"}, i, done_at[i], exp_done);
            check({name, ".found"}, i, int'(found_w[i]), ef[i]);
            check({name, ".x"}, i, int'(x_w[i]), ex[i]);
            check({name, ".y"}, i, int'(y_w[i]), ey[i]);
            check({name, ".match_count"}, i, int'(mc_w[i]), ec[i]);
            check({name, ".busy_idle"}, i, int'(busy_w[i]), 0);
        end
    endtask

    task automatic check_zero(input string name);
        for (int i = 0; i < 4; i++) begin
            check({name, ".busy"}, i, int'(busy_w[i]), 0);
            check({name, ".done"}, i, int'(done_w[i]), 0);
            check({name, ".found"}, i, int'(found_w[i]), 0);
            check({name, ".x"}, i, int'(x_w[i]), 0);
            check({name, ".y"}, i, int'(y_w[i]), 0);
            check({name, ".match_count"}, i, int'(mc_w[i]), 0);
        end
    endtask

    initial begin
        int d0 [4];
        vecs[0]  = '{2'd0, 2'd0, 1'b1, 20'd16, 11'd10, 10'd5};
        vecs[1]  = '{2'd0, 2'd1, 1'b1, 20'd16, 11'd13, 10'd5};
        vecs[2]  = '{2'd0, 2'd2, 1'b1, 20'd16, 11'd10, 10'd8};
        vecs[3]  = '{2'd0, 2'd3, 1'b1, 20'd16, 11'd13, 10'd8};
        vecs[4]  = '{2'd1, 2'd0, 1'b0, 20'd0, 11'd0, 10'd0};
        vecs[5]  = '{2'd1, 2'd1, 1'b0, 20'd0, 11'd0, 10'd0};
        vecs[6]  = '{2'd1, 2'd2, 1'b0, 20'd0, 11'd0, 10'd0};
        vecs[7]  = '{2'd1, 2'd3, 1'b0, 20'd0, 11'd0, 10'd0};
        vecs[8]  = '{2'd2, 2'd0, 1'b1, 20'd16, 11'd8, 10'd4};
        vecs[9]  = '{2'd2, 2'd1, 1'b1, 20'd16, 11'd43, 10'd20};
        vecs[10] = '{2'd2, 2'd2, 1'b1, 20'd16, 11'd4, 10'd8};
        vecs[11] = '{2'd2, 2'd3, 1'b1, 20'd16, 11'd43, 10'd20};
        vecs[12] = '{2'd3, 2'd0, 1'b1, 20'd16, 11'd5, 10'd3};
        vecs[13] = '{2'd3, 2'd1, 1'b1, 20'd16, 11'd20, 10'd3};
        vecs[14] = '{2'd3, 2'd2, 1'b1, 20'd16, 11'd5, 10'd3};
        vecs[15] = '{2'd3, 2'd3, 1'b1, 20'd16, 11'd20, 10'd3};
        for (int i = 0; i < 4; i++) begin
            done_cnt[i] = 0;
            done_at[i]  = 0;
        end
        build(1);
        for (int i = 0; i < 4; i++) tick(1'b0);
        #2 rst_n = 1'b1;
        tick(1'b0);
        check_zero("reset");

        build(0);
        advance_to(0);
        measure("block_framestart", 0, -1);
        build(1);
        advance_to(7 * HT + 30);
        measure("black", 1, -1);
        build(3);
        advance_to(HA + 3);
        measure("tolerance", 3, -1);
        build(0);
        advance_to(12 * HT + 5);
        measure("midframe_req", 0, FRAME);

        advance_to(20 * HT);
        tick(1'b1);
        for (int i = 0; i < FRAME && pos != 16 * HT; i++) tick(1'b0);
        for (int i = 0; i < 4; i++) check("abort.busy_scanning", i, int'(busy_w[i]), 1);
        #2 rst_n = 1'b0;
        #1 check_zero("abort");
        #1 rst_n = 1'b1;
        for (int i = 0; i < 4; i++) d0[i] = done_cnt[i];
        for (int i = 0; i < 2 * FRAME; i++) tick(1'b0);
        for (int i = 0; i < 4; i++) check("abort.no_done", i, done_cnt[i] - d0[i], 0);

        build(2);
        measure("tie_after_reset", 2, -1);
        for (int r = 0; r < 3; r++) begin
            build(4);
            advance_to($urandom_range(0, FRAME - 1));
            measure("random", -1, -1);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
